// File: rtl/seg_display_ctrl_pkg.sv
// Shared IO constants for the seven-segment display controller:
// the store address, blank/off patterns and the active-low hex glyph table.
package seg_display_ctrl_pkg;

  localparam logic [31:0] SEG_BASE_ADDR = 32'hFFFF_FF00;
  localparam logic [7:0]  SEG_BLANK     = 8'hFF;
  localparam logic [7:0]  AN_ALL_OFF    = 8'hFF;
  localparam int          NUM_DIGITS    = 8;

  // Segment order {dp,g,f,e,d,c,b,a}, active-low; dp is off in every glyph.
  localparam logic [7:0] HEX_SEG [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_hex_decoder
  import seg_display_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_display_ctrl.sv
// Eight-digit multiplexed seven-segment controller: holds the last stored word
// and scans its nibbles with dead time and optional leading-zero blanking.
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DEAD_CYC = 64,
  parameter int LZ_BLANK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seg_ctrl,
  input  logic [31:0] write_data,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out,
  output logic [31:0] disp_value
);

  localparam int              PW       = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(SCAN_DIV - 1);

  logic [31:0]   disp_reg;
  logic [PW-1:0] presc_reg, presc_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    an_reg, an_next;
  logic [7:0]    out_reg, out_next;

  logic [NUM_DIGITS-1:0] upper_nz;
  logic                  in_dead;
  logic                  blank;
  logic [3:0]            nibble;
  logic [7:0]            dec_seg;

  // upper_nz[i] is set when any nibble from i up to 7 is non-zero.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_nz
      assign upper_nz[gi] = |disp_reg[31:4*gi];
    end
  endgenerate

  generate
    if (DEAD_CYC == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (presc_reg < PW'(DEAD_CYC));
    end
  endgenerate

  assign blank  = (LZ_BLANK != 0) && (idx_reg != 3'd0) && !upper_nz[idx_reg];
  assign nibble = disp_reg[{idx_reg, 2'b00} +: 4];

  seg_hex_decoder u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    presc_next = presc_reg + 1'b1;
    idx_next   = idx_reg;
    if (presc_reg == PRE_LAST) begin
      presc_next = '0;
      idx_next   = idx_reg + 3'd1;
    end
  end

  // Decode works from the live display register, so a write shows mid-slot.
  always_comb begin
    an_next  = AN_ALL_OFF;
    out_next = SEG_BLANK;
    if (!in_dead && !blank) begin
      an_next  = ~(8'b1 << idx_reg);
      out_next = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg  <= '0;
      presc_reg <= '0;
      idx_reg   <= '0;
      an_reg    <= AN_ALL_OFF;
      out_reg   <= SEG_BLANK;
    end else begin
      if (seg_ctrl) disp_reg <= write_data;
      presc_reg <= presc_next;
      idx_reg   <= idx_next;
      an_reg    <= an_next;
      out_reg   <= out_next;
    end
  end

  assign seg_an     = an_reg;
  assign seg_out    = out_reg;
  assign disp_value = disp_reg;

endmodule
